regfile_op_sequencer: RTL and testbench

- Initiator-side controller for the 4-entry, 16-bit register file.
- Accepts one two-operand request at a time over a valid/ready handshake.
- Drives the file's two read ports, captures the operands, and computes a simple ALU result.
- Writes the result back through the file's write port, then signals completion.
- Sits between the instruction decode logic and the register file in the CPU datapath.

---
 rtl/regfile_op_sequencer.sv | 148 ++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_op_sequencer.sv
// Sequencer that reads two operands from a 4-entry register file, applies a small ALU op, and writes the result back.
// Optional zero/carry flags are enabled with the REGFILE_OP_SEQUENCER_FLAGS_EN macro.
module regfile_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [ADDR_W-1:0] req_src1,
    input  logic [ADDR_W-1:0] req_src2,
    output logic [ADDR_W-1:0] rf_r_addr1,
    output logic [ADDR_W-1:0] rf_r_addr2,
    input  logic [DATA_W-1:0] rf_r_data1,
    input  logic [DATA_W-1:0] rf_r_data2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
    output logic              flag_z,
    output logic              flag_c,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WRITE = 2'd3} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is registered and high only in IDLE, so req_* are ignored elsewhere.
    state_t            state, state_next;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] alu_res;
    logic              accept;

    assign accept    = (state == IDLE) && req_valid && req_ready;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
    // Extra top bit carries ADD carry-out or SUB borrow (set when a < b unsigned).
    logic alu_c;
    always_comb begin
        {alu_c, alu_res} = {1'b0, a_q};
        case (op_q)
            OP_ADD:  {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  {alu_c, alu_res} = {1'b0, a_q & b_q};
            default: {alu_c, alu_res} = {1'b0, a_q};
        endcase
    end
`else
    always_comb begin
        alu_res = a_q;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            default: alu_res = a_q;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake/strobe outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rf_we     <= 1'b0;
            done      <= 1'b0;
        end else begin
            req_ready <= (state_next == IDLE);
            rf_we     <= (state_next == WRITE);
            done      <= (state_next == WRITE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            dst_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rf_r_addr1 <= '0;
            rf_r_addr2 <= '0;
            rf_w_addr  <= '0;
            rf_w_data  <= '0;
            result     <= '0;
        end else begin
            if (accept) begin
                op_q       <= req_op;
                dst_q      <= req_dst;
                rf_r_addr1 <= req_src1;
                rf_r_addr2 <= req_src2;
            end
            // The file drives read data on the falling edge after the addresses change.
            if (state == READ) begin
                a_q <= rf_r_data1;
                b_q <= rf_r_data2;
            end
            if (state == EXEC) begin
                rf_w_addr <= dst_q;
                rf_w_data <= alu_res;
                result    <= alu_res;
            end
        end
    end

`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == EXEC) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 4-entry register file model.
// Define REGFILE_OP_SEQUENCER_FLAGS_EN to also check the zero/carry flags.
module tb_regfile_op_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_dst, req_src1, req_src2;
    logic [ADDR_W-1:0] rf_r_addr1, rf_r_addr2;
    logic [DATA_W-1:0] rf_r_data1, rf_r_data2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [1:0]        dbg_state;
`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
    logic              flag_z, flag_c;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        regs [4];

    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr;
    logic [DATA_W-1:0] poke_data;

    logic [1:0]        nxt_op;
    logic [ADDR_W-1:0] nxt_dst, nxt_src1, nxt_src2;

    regfile_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_dst    (req_dst),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .rf_r_addr1 (rf_r_addr1),
        .rf_r_addr2 (rf_r_addr2),
        .rf_r_data1 (rf_r_data1),
        .rf_r_data2 (rf_r_data2),
        .rf_we      (rf_we),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data),
        .done       (done),
        .result     (result),
`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
        .flag_z     (flag_z),
        .flag_c     (flag_c),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock and timeout
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Register file model: writes on the rising edge, read data updates on the falling edge.
    always @(posedge clk) begin
        logic [ADDR_W+DATA_W-1:0] exp_w;
        if (poke_en) regs[poke_addr] = poke_data;
        if (rf_we) begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("write", {rf_w_addr, rf_w_data}, exp_w);
            regs[rf_w_addr] = rf_w_data;
        end
    end

    always @(negedge clk) begin
        rf_r_data1 = regs[rf_r_addr1];
        rf_r_data2 = regs[rf_r_addr2];
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Drives one request and checks every cycle up to the return to IDLE.
    task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] dst, s1, s2,
                          input logic [DATA_W-1:0] exp, input logic ez, ec,
                          input bit noise, input bit hold_next);
        int w = 0;
        while (req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", req_ready, 1);
        exp_q.push_back({dst, exp});
        req_valid = 1'b1; req_op = op; req_dst = dst; req_src1 = s1; req_src2 = s2;
        @(negedge clk);
        check("read_busy", req_ready, 0);
        check("read_state", dbg_state, 1);
        check("raddr1", rf_r_addr1, s1);
        check("raddr2", rf_r_addr2, s2);
        if (noise) begin
            req_op = ~op; req_dst = ~dst; req_src1 = ~s1; req_src2 = ~s2;
        end else begin
            req_valid = 1'b0;
        end
        @(negedge clk);
        check("exec_busy", req_ready, 0);
        check("exec_we", rf_we, 0);
        check("exec_raddr1", rf_r_addr1, s1);
        check("exec_raddr2", rf_r_addr2, s2);
        @(negedge clk);
        check("write_busy", req_ready, 0);
        check("write_we", rf_we, 1);
        check("write_done", done, 1);
        check("waddr", rf_w_addr, dst);
        check("wdata", rf_w_data, exp);
        check("result", result, exp);
`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
        check("flag_z", flag_z, ez);
        check("flag_c", flag_c, ec);
`endif
        if (hold_next) begin
            req_valid = 1'b1; req_op = nxt_op; req_dst = nxt_dst;
            req_src1 = nxt_src1; req_src2 = nxt_src2;
        end
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("idle_we", rf_we, 0);
        check("idle_done", done, 0);
        check("idle_state", dbg_state, 0);
        check("result_hold", result, exp);
        check("rf_commit", regs[dst], exp);
        if (!hold_next) req_valid = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] saved;
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_dst = '0; req_src1 = '0; req_src2 = '0;
        nxt_op = '0; nxt_dst = '0; nxt_src1 = '0; nxt_src2 = '0;
        @(negedge clk);
        poke(0, 16'h0005);
        poke(1, 16'h0003);
        poke(2, 16'h0000);
        poke(3, 16'h0000);
        check("rst_ready", req_ready, 1);
        check("rst_we", rf_we, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        check("rst_outs", {rf_r_addr1, rf_r_addr2, rf_w_addr, rf_w_data, result}, 0);
`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
        check("rst_flags", {flag_z, flag_c}, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // ADD R2 = R0 + R1 = 5 + 3
        run_op(2'b00, 2'd2, 2'd0, 2'd1, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        // SUB R3 = R1 - R0 = 3 - 5 wraps, borrow set; junk requests during busy states
        run_op(2'b01, 2'd3, 2'd1, 2'd0, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0);
        check("noise_r2", regs[2], 16'h0008);

        // MOV R0 <- R2, then MOV R1 <- R0 back-to-back, reading the just-written R0
        poke(2, 16'h1234);
        nxt_op = 2'b11; nxt_dst = 2'd1; nxt_src1 = 2'd0; nxt_src2 = 2'd0;
        run_op(2'b11, 2'd0, 2'd2, 2'd3, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(2'b11, 2'd1, 2'd0, 2'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);

        // AND R3 = R1 & R2 = 0x1234 & 0x0F0F
        poke(2, 16'h0F0F);
        run_op(2'b10, 2'd3, 2'd1, 2'd2, 16'h0204, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted during EXEC: ADD R3 = R1 + R1 must never commit
        saved = regs[3];
        req_valid = 1'b1; req_op = 2'b00; req_dst = 2'd3; req_src1 = 2'd1; req_src2 = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_exec_state", dbg_state, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_outs", {rf_r_addr1, rf_r_addr2, rf_w_addr, rf_w_data, result}, 0);
`ifdef REGFILE_OP_SEQUENCER_FLAGS_EN
        check("mid_rst_flags", {flag_z, flag_c}, 0);
`endif
        @(negedge clk);
        check("mid_rst_dst", regs[3], saved);
        check("mid_rst_idle", dbg_state, 0);

        // Aliased ADD R0 = R0 + R0 with R0 = 0x8000 wraps to zero with carry
        poke(0, 16'h8000);
        run_op(2'b00, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("final_ready", req_ready, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
